// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB snoop and result buses of the integer ALU reservation station.
// The master side is the dispatcher/CDB; the slave side is the station itself.
interface alu_reservation_station_if #(
  parameter int TAG_W = 4
);
  logic             disp_valid_in;
  logic [4:0]       disp_op_in;
  logic [31:0]      disp_vj_in;
  logic [31:0]      disp_vk_in;
  logic [TAG_W-1:0] disp_qj_in;
  logic [TAG_W-1:0] disp_qk_in;
  logic             disp_pj_in;
  logic             disp_pk_in;
  logic [TAG_W-1:0] disp_dest_in;
  logic             full_out;
  logic             cdb_valid_in;
  logic [TAG_W-1:0] cdb_tag_in;
  logic [31:0]      cdb_value_in;
  logic             res_valid_out;
  logic [TAG_W-1:0] res_tag_out;
  logic [31:0]      res_value_out;

  modport master (
    output disp_valid_in, disp_op_in, disp_vj_in, disp_vk_in,
    output disp_qj_in, disp_qk_in, disp_pj_in, disp_pk_in, disp_dest_in,
    output cdb_valid_in, cdb_tag_in, cdb_value_in,
    input  full_out, res_valid_out, res_tag_out, res_value_out
  );

  modport slave (
    input  disp_valid_in, disp_op_in, disp_vj_in, disp_vk_in,
    input  disp_qj_in, disp_qk_in, disp_pj_in, disp_pk_in, disp_dest_in,
    input  cdb_valid_in, cdb_tag_in, cdb_value_in,
    output full_out, res_valid_out, res_tag_out, res_value_out
  );
endinterface

// File: rtl/alu_reservation_station.sv
// Integer ALU reservation station: buffers dispatched ops, snoops the CDB for
// pending operands and issues the lowest-index ready op into a combinational ALU.

module arithmetic_logic_unit (
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  logic [4:0] sh;
  assign sh = b[4:0];

  always_comb begin
    result = '0;
    if (op[4]) begin
      // compare mode with op[3] set is not a defined op; it yields zero
      if (!op[3]) begin
        case (op[2:0])
          3'b000:  result = {31'b0, a == b};
          3'b001:  result = {31'b0, a != b};
          3'b100:  result = {31'b0, $signed(a) < $signed(b)};
          3'b101:  result = {31'b0, $signed(a) >= $signed(b)};
          3'b110:  result = {31'b0, a < b};
          3'b111:  result = {31'b0, a >= b};
          default: result = '0;
        endcase
      end
    end else begin
      case (op[2:0])
        3'b000: begin
          if (op[3]) result = a - b;
          else       result = a + b;
        end
        3'b001:  result = a << sh;
        3'b010:  result = {31'b0, $signed(a) < $signed(b)};
        3'b011:  result = {31'b0, a < b};
        3'b100:  result = a ^ b;
        3'b101: begin
          // kept as separate statements so the arithmetic shift stays signed
          if (op[3]) result = $signed(a) >>> sh;
          else       result = a >> sh;
        end
        3'b110:  result = a | b;
        3'b111:  result = a & b;
        default: result = '0;
      endcase
    end
  end
endmodule

module alu_reservation_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      flush_in,
  alu_reservation_station_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);

  logic             busy_reg [DEPTH];
  logic             pj_reg   [DEPTH];
  logic             pk_reg   [DEPTH];
  logic [4:0]       op_reg   [DEPTH];
  logic [31:0]      vj_reg   [DEPTH];
  logic [31:0]      vk_reg   [DEPTH];
  logic [TAG_W-1:0] qj_reg   [DEPTH];
  logic [TAG_W-1:0] qk_reg   [DEPTH];
  logic [TAG_W-1:0] dest_reg [DEPTH];

  logic [DEPTH-1:0] ready;
  logic             full;
  logic             disp_fire;
  logic             issue_fire;
  logic [IDX_W-1:0] alloc_idx;
  logic [IDX_W-1:0] issue_idx;
  logic [31:0]      alu_result;

  logic             res_valid_reg;
  logic [TAG_W-1:0] res_tag_reg;
  logic [31:0]      res_value_reg;

  // Allocation and fullness look only at registered busy bits, so an entry
  // issuing this cycle is never reused until the next one.
  always_comb begin
    full      = 1'b1;
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_reg[i]) begin
        full      = 1'b0;
        alloc_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    issue_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) issue_idx = IDX_W'(i);
    end
  end

  assign issue_fire = |ready;
  assign disp_fire  = bus.disp_valid_in & ~full & ~flush_in;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic wr_en;
      logic iss_en;
      logic wake_j;
      logic wake_k;
      logic byp_j;
      logic byp_k;

      assign ready[gi] = busy_reg[gi] & ~pj_reg[gi] & ~pk_reg[gi];
      assign wr_en     = disp_fire && (alloc_idx == IDX_W'(gi));
      assign iss_en    = issue_fire && (issue_idx == IDX_W'(gi));
      assign wake_j    = busy_reg[gi] && pj_reg[gi] && bus.cdb_valid_in &&
                         (qj_reg[gi] == bus.cdb_tag_in);
      assign wake_k    = busy_reg[gi] && pk_reg[gi] && bus.cdb_valid_in &&
                         (qk_reg[gi] == bus.cdb_tag_in);
      assign byp_j     = bus.disp_pj_in && bus.cdb_valid_in &&
                         (bus.disp_qj_in == bus.cdb_tag_in);
      assign byp_k     = bus.disp_pk_in && bus.cdb_valid_in &&
                         (bus.disp_qk_in == bus.cdb_tag_in);

      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          busy_reg[gi] <= 1'b0;
          pj_reg[gi]   <= 1'b0;
          pk_reg[gi]   <= 1'b0;
          op_reg[gi]   <= '0;
          vj_reg[gi]   <= '0;
          vk_reg[gi]   <= '0;
          qj_reg[gi]   <= '0;
          qk_reg[gi]   <= '0;
          dest_reg[gi] <= '0;
        end else if (flush_in) begin
          busy_reg[gi] <= 1'b0;
        end else if (wr_en) begin
          busy_reg[gi] <= 1'b1;
          op_reg[gi]   <= bus.disp_op_in;
          qj_reg[gi]   <= bus.disp_qj_in;
          qk_reg[gi]   <= bus.disp_qk_in;
          dest_reg[gi] <= bus.disp_dest_in;
          pj_reg[gi]   <= bus.disp_pj_in & ~byp_j;
          pk_reg[gi]   <= bus.disp_pk_in & ~byp_k;
          vj_reg[gi]   <= byp_j ? bus.cdb_value_in : bus.disp_vj_in;
          vk_reg[gi]   <= byp_k ? bus.cdb_value_in : bus.disp_vk_in;
        end else begin
          if (iss_en) busy_reg[gi] <= 1'b0;
          if (wake_j) begin
            vj_reg[gi] <= bus.cdb_value_in;
            pj_reg[gi] <= 1'b0;
          end
          if (wake_k) begin
            vk_reg[gi] <= bus.cdb_value_in;
            pk_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  arithmetic_logic_unit u_alu (
    .op     (op_reg[issue_idx]),
    .a      (vj_reg[issue_idx]),
    .b      (vk_reg[issue_idx]),
    .result (alu_result)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      res_valid_reg <= 1'b0;
      res_tag_reg   <= '0;
      res_value_reg <= '0;
    end else if (flush_in) begin
      res_valid_reg <= 1'b0;
    end else begin
      res_valid_reg <= issue_fire;
      if (issue_fire) begin
        res_tag_reg   <= dest_reg[issue_idx];
        res_value_reg <= alu_result;
      end
    end
  end

  assign bus.full_out      = full;
  assign bus.res_valid_out = res_valid_reg;
  assign bus.res_tag_out   = res_tag_reg;
  assign bus.res_value_out = res_value_reg;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: directed vectors, corner
// sequences and randomized traffic against a per-cycle reference model.
module tb_alu_reservation_station;
  logic clk_in   = 1'b0;
  logic rst_in   = 1'b0;
  logic flush_in = 1'b0;
  int   total    = 0;
  int   bad      = 0;

  always #5 clk_in = ~clk_in;

  alu_reservation_station_if #(.TAG_W(4)) bus ();

  alu_reservation_station #(.DEPTH(4), .TAG_W(4)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .flush_in (flush_in),
    .bus      (bus)
  );

  typedef struct {
    logic        busy;
    logic [4:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [3:0]  qj;
    logic [3:0]  qk;
    logic        pj;
    logic        pk;
    logic [3:0]  dest;
  } ent_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  ent_t        m [4];
  logic        m_valid;
  logic [3:0]  m_tag;
  logic [31:0] m_value;
  vec_t        vecs [17];

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned        sh = 32'(b[4:0]);
    logic signed [31:0] sa = a;
    logic signed [31:0] sb = b;
    if (op[4]) begin
      if (op[3]) return '0;
      case (op[2:0])
        3'd0: return (a == b) ? 32'd1 : 32'd0;
        3'd1: return (a != b) ? 32'd1 : 32'd0;
        3'd4: return (sa < sb) ? 32'd1 : 32'd0;
        3'd5: return (sa >= sb) ? 32'd1 : 32'd0;
        3'd6: return (a < b) ? 32'd1 : 32'd0;
        3'd7: return (a >= b) ? 32'd1 : 32'd0;
        default: return '0;
      endcase
    end
    case (op[2:0])
      3'd0: return op[3] ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (op[3]) return sa >>> sh;
        return a >> sh;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic m_full();
    for (int i = 0; i < 4; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i].busy = 1'b0;
    m_valid = 1'b0;
    m_tag   = '0;
    m_value = '0;
  endtask

  // One clock of the station's behaviour, computed from the current inputs.
  task automatic model_update();
    logic old_busy [4];
    int   iss = -1;
    int   slot = -1;
    logic was_full = m_full();
    for (int i = 0; i < 4; i++) old_busy[i] = m[i].busy;
    if (flush_in) begin
      model_reset_busy_only();
      m_valid = 1'b0;
      return;
    end
    for (int i = 3; i >= 0; i--)
      if (m[i].busy && !m[i].pj && !m[i].pk) iss = i;
    m_valid = (iss >= 0);
    if (iss >= 0) begin
      m_tag   = m[iss].dest;
      m_value = ref_alu(m[iss].op, m[iss].vj, m[iss].vk);
      m[iss].busy = 1'b0;
    end
    if (bus.cdb_valid_in) begin
      for (int i = 0; i < 4; i++) begin
        if (m[i].busy && m[i].pj && m[i].qj == bus.cdb_tag_in) begin
          m[i].vj = bus.cdb_value_in;
          m[i].pj = 1'b0;
        end
        if (m[i].busy && m[i].pk && m[i].qk == bus.cdb_tag_in) begin
          m[i].vk = bus.cdb_value_in;
          m[i].pk = 1'b0;
        end
      end
    end
    if (bus.disp_valid_in && !was_full) begin
      for (int i = 3; i >= 0; i--) if (!old_busy[i]) slot = i;
      m[slot].busy = 1'b1;
      m[slot].op   = bus.disp_op_in;
      m[slot].vj   = bus.disp_vj_in;
      m[slot].vk   = bus.disp_vk_in;
      m[slot].qj   = bus.disp_qj_in;
      m[slot].qk   = bus.disp_qk_in;
      m[slot].pj   = bus.disp_pj_in;
      m[slot].pk   = bus.disp_pk_in;
      m[slot].dest = bus.disp_dest_in;
      if (bus.cdb_valid_in && m[slot].pj && m[slot].qj == bus.cdb_tag_in) begin
        m[slot].vj = bus.cdb_value_in;
        m[slot].pj = 1'b0;
      end
      if (bus.cdb_valid_in && m[slot].pk && m[slot].qk == bus.cdb_tag_in) begin
        m[slot].vk = bus.cdb_value_in;
        m[slot].pk = 1'b0;
      end
    end
  endtask

  task automatic model_reset_busy_only();
    for (int i = 0; i < 4; i++) m[i].busy = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk_in);
    #1;
    check("res_valid", 32'(bus.res_valid_out), 32'(m_valid));
    if (m_valid) begin
      check("res_tag", 32'(bus.res_tag_out), 32'(m_tag));
      check("res_value", bus.res_value_out, m_value);
    end
    check("full", 32'(bus.full_out), 32'(m_full()));
  endtask

  task automatic idle();
    bus.disp_valid_in = 1'b0;
    bus.cdb_valid_in  = 1'b0;
    flush_in          = 1'b0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                      input logic pj, input logic [3:0] qj, input logic pk,
                      input logic [3:0] qk, input logic [3:0] dest);
    bus.disp_valid_in = 1'b1;
    bus.disp_op_in    = op;
    bus.disp_vj_in    = vj;
    bus.disp_vk_in    = vk;
    bus.disp_pj_in    = pj;
    bus.disp_qj_in    = qj;
    bus.disp_pk_in    = pk;
    bus.disp_qk_in    = qk;
    bus.disp_dest_in  = dest;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] value);
    bus.cdb_valid_in = 1'b1;
    bus.cdb_tag_in   = tag;
    bus.cdb_value_in = value;
  endtask

  task automatic expect_result(input string name, input logic [3:0] tag,
                               input logic [31:0] value);
    check({name, "_valid"}, 32'(bus.res_valid_out), 32'd1);
    check({name, "_tag"}, 32'(bus.res_tag_out), 32'(tag));
    check({name, "_value"}, bus.res_value_out, value);
  endtask

  initial begin
    vecs[0]  = '{5'b00000, 32'd5,         32'd7,         32'd12};
    vecs[1]  = '{5'b01000, 32'd0,         32'd1,         32'hFFFFFFFF};
    vecs[2]  = '{5'b01101, 32'h80000000,  32'h24,        32'hF8000000};
    vecs[3]  = '{5'b00101, 32'h80000000,  32'h4,         32'h08000000};
    vecs[4]  = '{5'b00001, 32'd1,         32'h21,        32'd2};
    vecs[5]  = '{5'b00010, 32'hFFFFFFFF,  32'd1,         32'd1};
    vecs[6]  = '{5'b00011, 32'hFFFFFFFF,  32'd1,         32'd0};
    vecs[7]  = '{5'b00100, 32'hF0F0F0F0,  32'hFF00FF00,  32'h0FF00FF0};
    vecs[8]  = '{5'b00110, 32'hF0000000,  32'h0000000F,  32'hF000000F};
    vecs[9]  = '{5'b00111, 32'h12345678,  32'h0000FFFF,  32'h00005678};
    vecs[10] = '{5'b00000, 32'hFFFFFFFF,  32'd2,         32'd1};
    vecs[11] = '{5'b10000, 32'd7,         32'd7,         32'd1};
    vecs[12] = '{5'b10001, 32'd7,         32'd7,         32'd0};
    vecs[13] = '{5'b10100, 32'hFFFFFFFE,  32'd1,         32'd1};
    vecs[14] = '{5'b10101, 32'hFFFFFFFE,  32'd1,         32'd0};
    vecs[15] = '{5'b10110, 32'd9,         32'd1,         32'd0};
    vecs[16] = '{5'b10111, 32'd9,         32'd1,         32'd1};

    disp(5'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
    cdb(4'd0, 32'd0);
    idle();
    model_reset();
    #12;
    check("rst_valid", 32'(bus.res_valid_out), 32'd0);
    check("rst_tag", 32'(bus.res_tag_out), 32'd0);
    check("rst_value", bus.res_value_out, 32'd0);
    check("rst_full", 32'(bus.full_out), 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;

    // first op after reset: dispatch cycle 1, result cycle 3
    disp(5'b00000, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    step();
    idle();
    step();
    expect_result("first_add", 4'd3, 32'd12);

    for (int i = 0; i < 17; i++) begin
      disp(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 4'd0, 1'b0, 4'd0, 4'(i));
      step();
      idle();
      step();
      expect_result("vec", 4'(i), vecs[i].exp);
    end

    // wakeup from a broadcast two cycles after dispatch
    disp(5'b00111, 32'hDEAD, 32'hFF, 1'b1, 4'd6, 1'b0, 4'd0, 4'd5);
    step();
    idle();
    step();
    check("wake_no_early", 32'(bus.res_valid_out), 32'd0);
    cdb(4'd6, 32'h1234);
    step();
    check("wake_no_early2", 32'(bus.res_valid_out), 32'd0);
    idle();
    step();
    expect_result("wake", 4'd5, 32'h34);

    // dispatch-cycle bypass
    disp(5'b10110, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd7);
    cdb(4'd2, 32'd9);
    step();
    idle();
    step();
    expect_result("bypass", 4'd7, 32'd0);

    // fill all entries, ignored dispatch, out-of-order wakeup of entries 1 and 3
    disp(5'b00000, 32'd0, 32'd0,   1'b1, 4'd12, 1'b0, 4'd0, 4'd0); step();
    disp(5'b00000, 32'd0, 32'd100, 1'b1, 4'd11, 1'b0, 4'd0, 4'd1); step();
    disp(5'b00000, 32'd0, 32'd0,   1'b1, 4'd13, 1'b0, 4'd0, 4'd2); step();
    disp(5'b00000, 32'd0, 32'd300, 1'b1, 4'd11, 1'b0, 4'd0, 4'd3); step();
    check("fill_full", 32'(bus.full_out), 32'd1);
    disp(5'b00000, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    step();
    check("full_hold", 32'(bus.full_out), 32'd1);
    idle();
    cdb(4'd11, 32'd5);
    step();
    check("full_bcast", 32'(bus.full_out), 32'd1);
    idle();
    step();
    expect_result("full_e1", 4'd1, 32'd105);
    check("full_drop", 32'(bus.full_out), 32'd0);
    step();
    expect_result("full_e3", 4'd3, 32'd305);
    step();
    check("ignored_disp", 32'(bus.res_valid_out), 32'd0);

    // flush with three busy entries, one issuing, and a dispatch
    disp(5'b00000, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
    step();
    disp(5'b00000, 32'd2, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
    flush_in = 1'b1;
    step();
    check("flush_valid", 32'(bus.res_valid_out), 32'd0);
    check("flush_full", 32'(bus.full_out), 32'd0);
    idle();
    cdb(4'd12, 32'd1);
    step();
    cdb(4'd13, 32'd1);
    step();
    idle();
    step();
    check("flush_empty", 32'(bus.res_valid_out), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      int   k = $urandom_range(0, 16);
      logic [31:0] a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      logic [31:0] b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      idle();
      if ($urandom_range(0, 1) == 1)
        disp(vecs[k].op, a, b, ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 7)),
             ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1)
        cdb(4'($urandom_range(0, 7)), $urandom);
      flush_in = ($urandom_range(0, 49) == 0);
      step();
    end

    // asynchronous reset in the middle of a cycle with work in flight
    idle();
    flush_in = 1'b1;
    step();
    idle();
    disp(5'b00000, 32'd10, 32'd20, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1); step();
    disp(5'b00000, 32'd30, 32'd40, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2); step();
    idle();
    #2;
    rst_in = 1'b0;
    #1;
    model_reset();
    check("mid_rst_valid", 32'(bus.res_valid_out), 32'd0);
    check("mid_rst_tag", 32'(bus.res_tag_out), 32'd0);
    check("mid_rst_value", bus.res_value_out, 32'd0);
    check("mid_rst_full", 32'(bus.full_out), 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    step();
    check("mid_rst_discard", 32'(bus.res_valid_out), 32'd0);
    disp(5'b01000, 32'd50, 32'd8, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6);
    step();
    idle();
    step();
    expect_result("after_rst", 4'd6, 32'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
